// File: rtl/dac_twos_to_offset_driver.sv
// rtl/dac_twos_to_offset_driver.sv - slew-limited two's-complement to offset-binary DAC driver
module dac_twos_to_offset_driver #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 14,
    parameter int MAX_STEP  = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [OUT_WIDTH-1:0] dac_data,
    output logic                 dac_valid,
    output logic                 sat_flag,
    output logic                 busy
);

    // Reject parameter sets the datapath cannot represent.
    if (IN_WIDTH < OUT_WIDTH) begin : g_bad_width
        $error("IN_WIDTH must be >= OUT_WIDTH");
    end
    if (MAX_STEP < 1 || MAX_STEP > (2 ** OUT_WIDTH) - 1) begin : g_bad_step
        $error("MAX_STEP must be in 1 .. 2^OUT_WIDTH-1");
    end

    typedef enum logic {
        MUTE  = 1'b0,
        TRACK = 1'b1
    } state_t;

    localparam logic signed [IN_WIDTH-1:0] SAT_MAX  = IN_WIDTH'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [IN_WIDTH-1:0] SAT_MIN  = ~SAT_MAX;
    localparam logic signed [OUT_WIDTH:0]  STEP     = (OUT_WIDTH + 1)'(MAX_STEP);
    localparam logic signed [OUT_WIDTH:0]  NEG_STEP = (OUT_WIDTH + 1)'(-MAX_STEP);
    localparam logic [OUT_WIDTH-1:0]       MIDSCALE = {1'b1, {(OUT_WIDTH - 1){1'b0}}};

    state_t                       state_q, state_d;
    logic signed [OUT_WIDTH-1:0]  target_q, target_d;
    logic signed [OUT_WIDTH-1:0]  current_q, current_d;
    logic [OUT_WIDTH-1:0]         dac_data_q, dac_data_d;
    logic                         dac_valid_q, dac_valid_d;
    logic                         sat_flag_q, sat_flag_d;

    logic signed [IN_WIDTH-1:0]   sample;
    logic signed [OUT_WIDTH-1:0]  sat_value;
    logic                         clipped;
    logic                         accept;
    logic signed [OUT_WIDTH-1:0]  tgt_eff;
    logic signed [OUT_WIDTH:0]    tgt_ext;
    logic signed [OUT_WIDTH:0]    cur_ext;
    logic signed [OUT_WIDTH:0]    diff;

    // Clip the incoming sample into the signed range of the DAC word.
    always_comb begin
        sample    = signed'(in_data);
        clipped   = 1'b0;
        sat_value = sample[OUT_WIDTH-1:0];
        if (sample > SAT_MAX) begin
            sat_value = SAT_MAX[OUT_WIDTH-1:0];
            clipped   = 1'b1;
        end else if (sample < SAT_MIN) begin
            sat_value = SAT_MIN[OUT_WIDTH-1:0];
            clipped   = 1'b1;
        end
    end

    // Handshake: a new sample only when tracking, enabled and the ramp has settled.
    always_comb begin
        busy     = (current_q != target_q);
        in_ready = !rst && en && (state_q == TRACK) && !busy;
        accept   = in_valid && in_ready;
    end

    // Next state, target and slew-limited step; muting pulls the ramp to zero at once.
    always_comb begin
        state_d  = en ? TRACK : MUTE;
        target_d = target_q;
        if (accept) begin
            target_d = sat_value;
        end
        if (state_d == MUTE) begin
            target_d = '0;
        end

        tgt_eff = (state_d == MUTE) ? '0 : target_q;
        tgt_ext = {tgt_eff[OUT_WIDTH-1], tgt_eff};
        cur_ext = {current_q[OUT_WIDTH-1], current_q};
        diff    = tgt_ext - cur_ext;

        if (diff > STEP) begin
            current_d = OUT_WIDTH'(cur_ext + STEP);
        end else if (diff < NEG_STEP) begin
            current_d = OUT_WIDTH'(cur_ext + NEG_STEP);
        end else begin
            current_d = tgt_eff;
        end

        dac_data_d  = {~current_d[OUT_WIDTH-1], current_d[OUT_WIDTH-2:0]};
        dac_valid_d = (dac_data_d != dac_data_q);
        sat_flag_d  = accept && clipped;
    end

    // State and datapath registers with synchronous reset to midscale.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= MUTE;
            target_q    <= '0;
            current_q   <= '0;
            dac_data_q  <= MIDSCALE;
            dac_valid_q <= 1'b0;
            sat_flag_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            current_q   <= current_d;
            dac_data_q  <= dac_data_d;
            dac_valid_q <= dac_valid_d;
            sat_flag_q  <= sat_flag_d;
        end
    end

    assign dac_data  = dac_data_q;
    assign dac_valid = dac_valid_q;
    assign sat_flag  = sat_flag_q;

endmodule

// File: tb/tb_dac_twos_to_offset_driver.sv
// tb/tb_dac_twos_to_offset_driver.sv - scoreboard bench for dac_twos_to_offset_driver
module tb_dac_twos_to_offset_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [13:0] dac_data;
    logic        dac_valid;
    logic        sat_flag;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int sat_q[$];

    dac_twos_to_offset_driver #(
        .IN_WIDTH (16),
        .OUT_WIDTH(14),
        .MAX_STEP (64)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .dac_data (dac_data),
        .dac_valid(dac_valid),
        .sat_flag (sat_flag),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every dac_valid pulse must match the next queued code; every sat pulse must be expected.
    always @(negedge clk) begin
        if (dac_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dac_unexpected: got 0x%0h expected no pulse", dac_data);
            end else begin
                check("dac_seq", int'(dac_data), exp_q.pop_front());
            end
        end
        if (sat_flag) begin
            if (sat_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sat_unexpected: got 1 expected 0");
            end else begin
                check("sat_seq", 1, sat_q.pop_front());
            end
        end
    end

    task automatic send(input logic [15:0] d, input bit exp_sat);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("ready_timeout", int'(in_ready), 1);
            return;
        end
        in_data  = d;
        in_valid = 1'b1;
        if (exp_sat) sat_q.push_back(1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("sat_flag_after_accept", int'(sat_flag), int'(exp_sat));
    endtask

    task automatic wait_idle(input int max_cyc, output bit ready_seen);
        int n = 0;
        ready_seen = 1'b0;
        while (busy && n < max_cyc) begin
            if (in_ready) ready_seen = 1'b1;
            @(negedge clk);
            n++;
        end
        check("idle_timeout", int'(busy), 0);
    endtask

    task automatic wait_dac(input int code, input int max_cyc);
        int n = 0;
        while (int'(dac_data) != code && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check("wait_dac_code", int'(dac_data), code);
    endtask

    initial begin
        bit rs;
        int n;
        rst      = 1'b1;
        en       = 1'b1;
        in_data  = '0;
        in_valid = 1'b0;

        // Reset held 3 cycles with en high.
        repeat (3) begin
            @(negedge clk);
            check("rst_dac", int'(dac_data), 'h2000);
            check("rst_ready", int'(in_ready), 0);
        end
        check("rst_valid", int'(dac_valid), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b0;
        #1;
        check("release_ready0", int'(in_ready), 0);
        @(negedge clk);
        check("release_ready1", int'(in_ready), 1);

        // Small step within MAX_STEP: 2-cycle latency, single pulse.
        exp_q.push_back('h2010);
        send(16'h0010, 1'b0);
        @(negedge clk);
        check("small_dac", int'(dac_data), 'h2010);
        check("small_valid", int'(dac_valid), 1);
        check("small_busy", int'(busy), 0);
        @(negedge clk);
        check("small_single_pulse", int'(dac_valid), 0);

        // Back to zero.
        exp_q.push_back('h2000);
        send(16'h0000, 1'b0);
        wait_idle(10, rs);

        // Positive full-scale clip: 128 steps up to 0x3FFF.
        for (int k = 1; k < 128; k++) exp_q.push_back('h2000 + 64 * k);
        exp_q.push_back('h3FFF);
        send(16'h7FFF, 1'b1);
        wait_idle(300, rs);
        check("up_ready_during_ramp", int'(rs), 0);
        check("up_final", int'(dac_data), 'h3FFF);
        check("up_ready_after", int'(in_ready), 1);

        // Negative full-scale clip: 256 steps down to 0x0000.
        for (int k = 1; k < 256; k++) exp_q.push_back('h3FFF - 64 * k);
        exp_q.push_back('h0000);
        send(16'h8000, 1'b1);
        wait_idle(400, rs);
        check("down_ready_during_ramp", int'(rs), 0);
        check("down_final", int'(dac_data), 'h0000);

        // Mute mid-ramp at 0x3000: ramp back to midscale, inputs ignored.
        for (int k = 1; k <= 192; k++) exp_q.push_back(64 * k);
        for (int k = 1; k <= 64; k++) exp_q.push_back('h3000 - 64 * k);
        send(16'h7FFF, 1'b1);
        wait_dac('h3000, 400);
        en       = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'h7000;
        wait_idle(200, rs);
        check("mute_ready_during_ramp", int'(rs), 0);
        check("mute_dac", int'(dac_data), 'h2000);
        repeat (3) @(negedge clk);
        check("mute_ready_idle", int'(in_ready), 0);
        in_valid = 1'b0;
        en       = 1'b1;
        @(negedge clk);
        check("unmute_ready", int'(in_ready), 1);
        check("unmute_dac", int'(dac_data), 'h2000);
        check("unmute_valid", int'(dac_valid), 0);

        // Reset mid-ramp aborts immediately with no pulse.
        for (int k = 1; k <= 16; k++) exp_q.push_back('h2000 + 64 * k);
        send(16'h1000, 1'b0);
        wait_dac('h2400, 100);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_dac", int'(dac_data), 'h2000);
        check("rst_mid_valid", int'(dac_valid), 0);
        check("rst_mid_busy", int'(busy), 0);
        rst = 1'b0;
        n = 0;
        repeat (4) @(negedge clk);
        check("rst_mid_quiet", int'(dac_data), 'h2000);

        check("dac_queue_empty", exp_q.size(), 0);
        check("sat_queue_empty", sat_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dac_twos_to_offset_driver.md
DAC_TWOS_TO_OFFSET_DRIVER -- requirements
Module: dac_twos_to_offset_driver

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 16, width of the signed two's-complement input sample.
REQ-002 SHALL have parameter OUT_WIDTH, default 14, width of the offset-binary DAC word.
REQ-003 SHALL have parameter MAX_STEP, default 64, the maximum change of the output code per clock.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, reset that is synchronous and active-high.
REQ-006 SHALL have port en, input, 1 bit, output enable; low mutes the output to midscale.
REQ-007 SHALL have port in_data, input, IN_WIDTH bits, signed two's-complement target sample.
REQ-008 SHALL have port in_valid, input, 1 bit, meaning in_data is valid.
REQ-009 SHALL have port in_ready, output, 1 bit, meaning the block accepts a sample this cycle.
REQ-010 SHALL have port dac_data, output, OUT_WIDTH bits, the registered offset-binary DAC code.
REQ-011 SHALL have port dac_valid, output, 1 bit, a one-cycle pulse on each dac_data change.
REQ-012 SHALL have port sat_flag, output, 1 bit, a one-cycle pulse when an accepted sample was clipped.
REQ-013 SHALL have port busy, output, 1 bit, high while the current code differs from the target.

Function
REQ-014 SHALL require IN_WIDTH >= OUT_WIDTH and 1 <= MAX_STEP <= 2^OUT_WIDTH-1, checked at elaboration.
REQ-015 SHALL accept a sample only on a cycle where in_valid and in_ready are both high.
REQ-016 SHALL saturate an accepted sample to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] and load the result into an internal signed target register at the end of the accept cycle.
REQ-017 SHALL pulse sat_flag in the cycle after acceptance when clipping occurred.
REQ-018 SHALL keep an internal signed register "current", which each cycle moves toward target by min(|target-current|, MAX_STEP) without overshoot.
REQ-019 SHALL load dac_data on the same edge as current, with the value next_current with its MSB inverted (offset binary; 0 maps to 2^(OUT_WIDTH-1)).
REQ-020 SHALL give a latency of 2 cycles from accept cycle N to dac_data for a step of at most MAX_STEP: target is loaded at the end of N, and dac_data is valid in cycle N+2.
REQ-021 SHALL assert dac_valid in exactly the cycles in which dac_data differs from its previous value.
REQ-022 SHALL assert busy combinationally as (current != target).
REQ-023 SHALL implement a state machine with states MUTE and TRACK.
REQ-024 SHALL make the MUTE to TRACK transition on the edge where en is sampled high.
REQ-025 SHALL make the TRACK to MUTE transition on the edge where en is sampled low, even mid-ramp.
REQ-026 SHALL, in MUTE, force target to 0 every cycle, hold in_ready low and ignore in_valid, so current ramps to 0 at MAX_STEP per cycle.
REQ-027 SHALL, in TRACK, drive in_ready = !busy, so there are no new samples during a ramp and no buffering.
REQ-028 SHALL leave target at 0 after re-entry to TRACK until a sample is accepted.
REQ-029 SHALL compute the difference at OUT_WIDTH+1 bits so that a full-scale swing from -2^(OUT_WIDTH-1) to 2^(OUT_WIDTH-1)-1 does not overflow.
REQ-030 SHALL produce, in the final step when |diff| <= MAX_STEP, a current exactly equal to target.

Reset
REQ-031 SHALL, while rst is high at a clock edge, set state=MUTE, target=0, current=0, dac_data=2^(OUT_WIDTH-1), dac_valid=0 and sat_flag=0.
REQ-032 SHALL hold in_ready low while rst is high and in the cycle after rst is released.
REQ-033 SHALL let rst mid-ramp abort the ramp, with dac_data at midscale in the cycle after the reset edge and no dac_valid pulse.
REQ-034 SHALL have no asynchronous reset path.

Verification
REQ-035 SHALL cover this scenario: rst high 3 cycles with en=1, then released -> dac_data=0x2000 and in_ready=0 during reset; in_ready=1 from the 2nd cycle after release.
REQ-036 SHALL cover this scenario: in TRACK, accept in_data=16'h0010 -> dac_data=0x2010 two cycles later, a single dac_valid pulse, busy low again, sat_flag=0.
REQ-037 SHALL cover this scenario: from 0, accept 16'h7FFF -> sat_flag pulse; dac_data steps 0x2040, 0x2080, ... and reaches 0x3FFF after 128 steps; in_ready low throughout, then high.
REQ-038 SHALL cover this scenario: from 0x3FFF, accept 16'h8000 -> clip to -8192 with sat_flag; dac_data descends by 64 per cycle and ends at exactly 0x0000 after 256 steps.
REQ-039 SHALL cover this scenario: drop en mid-ramp at 0x3000 -> dac_data ramps down by 64 to exactly 0x2000; in_valid pulses ignored; raising en gives in_ready=1 the next cycle and dac_data stays 0x2000.
REQ-040 SHALL cover this scenario: assert rst mid-ramp -> dac_data=0x2000, dac_valid=0 and busy=0 in the following cycle.
